// File: rtl/supersonic_ranger_if.sv
// Controller-side handshake of the ultrasonic ranger: measurement request in,
// trig acknowledge and held range result out.
interface supersonic_ranger_if;
  logic       trigger;
  logic       triggerSuc;
  logic       valid;
  logic       distance;
  logic       out_range;
  logic [8:0] dist_cm;

  modport master (output trigger, input triggerSuc, valid, distance, out_range, dist_cm);
  modport slave  (input trigger, output triggerSuc, valid, distance, out_range, dist_cm);
endinterface

// File: rtl/supersonic_ranger.sv
// HC-SR04 front end: issues the trig pulse, times the synchronized echo in
// microsecond ticks, converts to centimetres and holds the result until the next one.
module supersonic_ranger #(
  parameter int CLK_MHZ      = 50,
  parameter int TRIG_US      = 10,
  parameter int US_PER_CM    = 58,
  parameter int MAX_CM       = 400,
  parameter int THRESH_CM    = 30,
  parameter int ECHO_WAIT_US = 30000,
  parameter int HOLDOFF_US   = 60000
) (
  input  logic               clk,
  input  logic               rst_n,
  supersonic_ranger_if.slave bus,
  output logic               sr_trig,
  input  logic               sr_echo
);
  localparam int TRIG_CYC = TRIG_US * CLK_MHZ;
  localparam int TW   = $clog2(TRIG_CYC);
  localparam int PW   = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
  localparam int UW   = (US_PER_CM > 1) ? $clog2(US_PER_CM) : 1;
  localparam int CW   = $clog2(MAX_CM + 1);
  localparam int TMAX = (ECHO_WAIT_US > HOLDOFF_US) ? ECHO_WAIT_US : HOLDOFF_US;
  localparam int TMW  = $clog2(TMAX + 1);

  localparam logic [TW-1:0]  TRIG_LAST  = TW'(TRIG_CYC - 1);
  localparam logic [TW-1:0]  TRIG_PRE   = TW'(TRIG_CYC - 2);
  localparam logic [PW-1:0]  PRESC_LAST = PW'(CLK_MHZ - 1);
  localparam logic [UW-1:0]  US_LAST    = UW'(US_PER_CM - 1);
  localparam logic [CW-1:0]  CM_MAX     = CW'(MAX_CM);
  localparam logic [CW-1:0]  CM_THRESH  = CW'(THRESH_CM);
  localparam logic [TMW-1:0] ECHO_T     = TMW'(ECHO_WAIT_US);
  localparam logic [TMW-1:0] HOLD_T     = TMW'(HOLDOFF_US);

  typedef enum logic [2:0] {
    S_IDLE, S_TRIG, S_WAIT_RISE, S_MEASURE, S_DONE, S_HOLDOFF
  } state_t;

  typedef struct packed {
    logic       distance;
    logic       out_range;
    logic [8:0] dist_cm;
  } result_t;

  state_t         state_q, state_d;
  logic [TW-1:0]  trig_cnt_q, trig_cnt_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic [UW-1:0]  us_q, us_d;
  logic [CW-1:0]  cm_q, cm_d;
  logic [TMW-1:0] tmr_q, tmr_d;
  logic           sr_trig_q, sr_trig_d;
  logic           trig_suc_q, trig_suc_d;
  logic           valid_q, valid_d;
  result_t        res_q, res_d;
  logic           echo_meta_q, echo_s_q;

  logic           presc_wrap;
  logic [PW-1:0]  presc_inc;
  logic [TMW-1:0] tmr_nxt;
  logic [CW-1:0]  cm_nxt;
  logic           fin, fin_to;

  always_comb begin
    presc_wrap = (presc_q == PRESC_LAST);
    presc_inc  = presc_wrap ? '0 : presc_q + 1'b1;
    tmr_nxt    = presc_wrap ? tmr_q + 1'b1 : tmr_q;
    cm_nxt     = (presc_wrap && us_q == US_LAST) ? cm_q + 1'b1 : cm_q;
  end

  always_comb begin
    state_d    = state_q;
    trig_cnt_d = trig_cnt_q;
    presc_d    = presc_q;
    us_d       = us_q;
    cm_d       = cm_q;
    tmr_d      = tmr_q;
    sr_trig_d  = sr_trig_q;
    trig_suc_d = 1'b0;
    valid_d    = 1'b0;
    res_d      = res_q;
    fin        = 1'b0;
    fin_to     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.trigger) begin
          state_d    = S_TRIG;
          sr_trig_d  = 1'b1;
          trig_cnt_d = '0;
        end
      end
      S_TRIG: begin
        trig_cnt_d = trig_cnt_q + 1'b1;
        // Acknowledge is registered, so raise it one cycle early to line up with the last trig cycle.
        if (trig_cnt_q == TRIG_PRE) trig_suc_d = 1'b1;
        if (trig_cnt_q == TRIG_LAST) begin
          state_d    = S_WAIT_RISE;
          sr_trig_d  = 1'b0;
          trig_cnt_d = '0;
          presc_d    = '0;
          tmr_d      = '0;
        end
      end
      S_WAIT_RISE: begin
        presc_d = presc_inc;
        tmr_d   = tmr_nxt;
        if (echo_s_q) begin
          state_d = S_MEASURE;
          presc_d = '0;
          us_d    = '0;
          cm_d    = '0;
        end else if (tmr_nxt == ECHO_T) begin
          fin    = 1'b1;
          fin_to = 1'b1;
        end
      end
      S_MEASURE: begin
        // The rise-detect cycle is not counted but the fall-detect cycle is,
        // so exactly the true echo width is accumulated.
        presc_d = presc_inc;
        if (presc_wrap) us_d = (us_q == US_LAST) ? '0 : us_q + 1'b1;
        cm_d = cm_nxt;
        if (cm_nxt == CM_MAX) begin
          fin    = 1'b1;
          fin_to = 1'b1;
        end else if (!echo_s_q) begin
          fin = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_HOLDOFF;
        presc_d = '0;
        tmr_d   = '0;
      end
      S_HOLDOFF: begin
        presc_d = presc_inc;
        tmr_d   = tmr_nxt;
        if (tmr_nxt == HOLD_T) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (fin) begin
      state_d         = S_DONE;
      valid_d         = 1'b1;
      res_d.out_range = fin_to;
      res_d.dist_cm   = fin_to ? 9'(CM_MAX) : 9'(cm_nxt);
      res_d.distance  = !fin_to && (cm_nxt < CM_THRESH);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      trig_cnt_q  <= '0;
      presc_q     <= '0;
      us_q        <= '0;
      cm_q        <= '0;
      tmr_q       <= '0;
      sr_trig_q   <= 1'b0;
      trig_suc_q  <= 1'b0;
      valid_q     <= 1'b0;
      res_q       <= '0;
      echo_meta_q <= 1'b0;
      echo_s_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      trig_cnt_q  <= trig_cnt_d;
      presc_q     <= presc_d;
      us_q        <= us_d;
      cm_q        <= cm_d;
      tmr_q       <= tmr_d;
      sr_trig_q   <= sr_trig_d;
      trig_suc_q  <= trig_suc_d;
      valid_q     <= valid_d;
      res_q       <= res_d;
      echo_meta_q <= sr_echo;
      echo_s_q    <= echo_meta_q;
    end
  end

  assign sr_trig        = sr_trig_q;
  assign bus.triggerSuc = trig_suc_q;
  assign bus.valid      = valid_q;
  assign bus.distance   = res_q.distance;
  assign bus.out_range  = res_q.out_range;
  assign bus.dist_cm    = res_q.dist_cm;
endmodule

// File: tb/tb_supersonic_ranger.sv
// Randomized and directed bench for supersonic_ranger; expected ranges come
// from floor(echo_cycles / cycles_per_cm) with saturation at MAX_CM.
module tb_supersonic_ranger;
  localparam int M       = 2;
  localparam int TRIG_US = 10;
  localparam int UPC     = 58;
  localparam int MAXC    = 110;
  localparam int THR     = 30;
  localparam int EW      = 2000;
  localparam int HO      = 10;
  localparam int TRIG_CYC = M * TRIG_US;
  localparam int ECHO_CYC = M * EW;
  localparam int HOLD_CYC = M * HO;
  localparam int CM_CYC   = M * UPC;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sr_trig;
  logic sr_echo = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  supersonic_ranger_if bus();

  supersonic_ranger #(
    .CLK_MHZ(M), .TRIG_US(TRIG_US), .US_PER_CM(UPC), .MAX_CM(MAXC),
    .THRESH_CM(THR), .ECHO_WAIT_US(EW), .HOLDOFF_US(HO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .sr_trig(sr_trig), .sr_echo(sr_echo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model(input bit echo_on, input int wc, output int ed, output int ef, output int eo);
    int cm;
    cm = echo_on ? wc / CM_CYC : MAXC;
    if (cm >= MAXC) begin
      ed = MAXC; eo = 1; ef = 0;
    end else begin
      ed = cm; eo = 0; ef = (cm < THR) ? 1 : 0;
    end
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_sr_trig"}, int'(sr_trig), 0);
    chk({tag, "_suc"},     int'(bus.triggerSuc), 0);
    chk({tag, "_valid"},   int'(bus.valid), 0);
    chk({tag, "_dist"},    int'(bus.dist_cm), 0);
    chk({tag, "_flag"},    int'(bus.distance), 0);
    chk({tag, "_orng"},    int'(bus.out_range), 0);
  endtask

  task automatic run_meas(input string tag, input int gap, input int wc,
                          input bit echo_on, input bit busy, input bit hold);
    int n_hi, suc_n, suc_cyc, last_cyc, nv, vcyc, rise_cyc, budget;
    int ed, ef, eo, gd, gf, go;
    model(echo_on, wc, ed, ef, eo);
    n_hi = 0; suc_n = 0; suc_cyc = -1; last_cyc = -2;
    nv = 0; vcyc = -1; rise_cyc = -1; gd = -1; gf = -1; go = -1;
    bus.trigger = 1'b1;
    for (int i = 0; i < TRIG_CYC + 20; i++) begin
      @(negedge clk);
      if (!hold) bus.trigger = 1'b0;
      if (sr_trig) begin n_hi++; last_cyc = cyc; end
      if (bus.triggerSuc) begin suc_n++; suc_cyc = cyc; end
    end
    chk({tag, "_trig_len"}, n_hi, TRIG_CYC);
    chk({tag, "_suc_cnt"}, suc_n, 1);
    chk({tag, "_suc_pos"}, suc_cyc, last_cyc);
    budget = (echo_on ? gap + wc : ECHO_CYC) + HOLD_CYC + 40;
    for (int j = 0; j < budget; j++) begin
      @(negedge clk);
      if (bus.valid) begin
        nv++; vcyc = cyc;
        gd = int'(bus.dist_cm); gf = int'(bus.distance); go = int'(bus.out_range);
      end
      if (sr_trig && rise_cyc < 0) rise_cyc = cyc;
      sr_echo = echo_on && j >= gap && j < gap + wc;
      if (busy) bus.trigger = (j == gap + wc / 2) || (vcyc >= 0 && cyc == vcyc + 5);
      if (hold && rise_cyc >= 0) break;
    end
    sr_echo = 1'b0;
    chk({tag, "_valid_cnt"}, nv, 1);
    chk({tag, "_dist"}, gd, ed);
    chk({tag, "_flag"}, gf, ef);
    chk({tag, "_orng"}, go, eo);
    if (!echo_on) chk({tag, "_timeout_lat"}, vcyc - suc_cyc, ECHO_CYC + 1);
    if (hold) begin
      chk({tag, "_retrig_lat"}, rise_cyc - vcyc, HOLD_CYC + 2);
    end else begin
      chk({tag, "_no_retrig"}, int'(rise_cyc >= 0), 0);
      chk({tag, "_held_dist"}, int'(bus.dist_cm), ed);
      chk({tag, "_held_orng"}, int'(bus.out_range), eo);
    end
  endtask

  task automatic reset_mid();
    int nv;
    bus.trigger = 1'b1;
    @(negedge clk);
    bus.trigger = 1'b0;
    repeat (TRIG_CYC + 10) @(negedge clk);
    sr_echo = 1'b1;
    repeat (500 * M) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_outs_zero("rst_mid");
    sr_echo = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    nv = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (bus.valid) nv++;
    end
    chk("rst_mid_no_valid", nv, 0);
    chk("rst_mid_dist_after", int'(bus.dist_cm), 0);
  endtask

  initial begin
    bus.trigger = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_outs_zero("rst");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_no_trig", int'(sr_trig), 0);

    run_meas("near",   5,  1450 * M,     1'b1, 1'b0, 1'b0);
    run_meas("edge24", 3,  1450 * M - 1, 1'b1, 1'b0, 1'b0);
    run_meas("thr30",  7,  THR * CM_CYC, 1'b1, 1'b0, 1'b0);
    run_meas("far",    10, 5800 * M,     1'b1, 1'b0, 1'b0);
    reset_mid();
    run_meas("noecho", 0,  0,             1'b0, 1'b0, 1'b0);
    run_meas("sat",    4,  MAXC * CM_CYC, 1'b1, 1'b0, 1'b0);
    run_meas("busy",   6,  800 * M,       1'b1, 1'b1, 1'b0);
    run_meas("hold",   6,  600 * M,       1'b1, 1'b0, 1'b1);

    // The held trigger has started another measurement; reset must kill sr_trig at once.
    bus.trigger = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_in_trig", int'(sr_trig), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 6; r++) begin
      int wc, gap;
      wc  = int'($urandom_range(3000, 100));
      gap = int'($urandom_range(30, 0));
      run_meas("rnd", gap, wc, 1'b1, 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
